rr_bus_arbiter: RTL and testbench

- Round-robin arbiter that shares one 8-bit output bus between NUM_REQ requesters.
- Each requester has a valid/ready handshake. A grant is held for a burst, and the burst ends on req_last or after MAX_BURST beats.
- Output is a single registered stage. The block also drives a continuous sub-field out_slice = out_data[4:1].
- Sits in front of the shared vector datapath and sequences which source drives it.

---
 rtl/rr_bus_arbiter.sv | 143 ++++++++++++++
 tb/tb_rr_bus_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_bus_arbiter.sv
// Round-robin arbiter sharing one registered output bus between requesters.
// Grants are held for a burst ending on req_last or after MAX_BURST beats.
module rr_bus_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_last,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         out_data,
  output logic [3:0]                out_slice,
  output logic [2:0]                out_src,
  input  logic                      out_ready,
  output logic                      busy
);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_GRANT  = 1'b1;
  localparam logic [2:0] LAST_RST = 3'(NUM_REQ - 1);
  localparam logic [3:0] MAX_B    = 4'(MAX_BURST);

  logic [0:0]        state_q, state_d;
  logic [2:0]        g_q, g_d;
  logic [2:0]        last_q, last_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [2:0]        out_src_q, out_src_d;

  logic [2:0]        pick;
  logic              sel_valid;
  logic              sel_last;
  logic [DATA_W-1:0] sel_data;
  logic              can_load;
  logic              xfer;
  logic              burst_end;

  // Descending distance scan: the closest requester after last_q wins.
  always_comb begin
    pick = last_q;
    for (int k = NUM_REQ; k >= 1; k--) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (req_valid[j] && j == (int'(last_q) + k) % NUM_REQ)
          pick = 3'(j);
      end
    end
  end

  // Only the granted lane is looked at, so X on other lanes stays out.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (g_q == 3'(i)) begin
        sel_valid = req_valid[i];
        sel_last  = req_last[i];
        sel_data  = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign can_load  = !out_valid_q || out_ready;
  assign busy      = (state_q == S_GRANT);
  assign xfer      = busy && sel_valid && can_load;
  assign burst_end = xfer && (sel_last || (cnt_q + 4'd1 == MAX_B));

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++)
      req_ready[i] = busy && (g_q == 3'(i)) && can_load;
  end

  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (|req_valid) begin
          state_d = S_GRANT;
          g_d     = pick;
          last_d  = pick;
          cnt_d   = 4'd0;
        end
      end
      S_GRANT: begin
        if (burst_end) begin
          state_d = S_IDLE;
          cnt_d   = 4'd0;
        end else if (xfer) begin
          cnt_d   = cnt_q + 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = sel_data;
      out_src_d   = g_q;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      g_q         <= 3'd0;
      last_q      <= LAST_RST;
      cnt_q       <= 4'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= 3'd0;
    end else begin
      state_q     <= state_d;
      g_q         <= g_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;
  assign out_slice = out_data_q[4:1];

endmodule

// File: tb/tb_rr_bus_arbiter.sv
// Directed bench for rr_bus_arbiter: one task per scenario.
// Inputs change and outputs are sampled around the falling edge.
module tb_rr_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [3:0]  req_last = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [3:0]  out_slice;
  logic [2:0]  out_src;
  logic        out_ready = 1'b1;
  logic        busy;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  rr_bus_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_last  (req_last),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_slice (out_slice),
    .out_src   (out_src),
    .out_ready (out_ready),
    .busy      (busy)
  );

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req_valid = '0;
    req_last = '0;
    req_data = '0;
    out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_chk++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: valid=%b busy=%b want 0 0", out_valid, busy);
    end
    n_chk++;
    if (req_ready !== 4'b0 || out_data !== 8'h00 || out_src !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_regs: ready=%b data=%h src=%0d want 0", req_ready, out_data, out_src);
    end
    n_chk++;
    if (out_slice !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_slice: got %h want 0", out_slice);
    end
    rst = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    req_data = 'x;
    req_data[15:8] = 8'hA5;
    req_valid = 4'b0010;
    req_last = 4'b0010;
    #1;
    n_chk++;
    if (req_ready !== 4'b0000) begin
      n_fail++;
      $display("FAIL single_idle_ready: got %b want 0000", req_ready);
    end
    @(negedge clk);
    n_chk++;
    if (req_ready !== 4'b0010 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_grant: ready=%b busy=%b want 0010 1", req_ready, busy);
    end
    @(negedge clk);
    req_valid = '0;
    #1;
    n_chk++;
    if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_src !== 3'd1) begin
      n_fail++;
      $display("FAIL single_out: v=%b d=%h s=%0d want 1 a5 1", out_valid, out_data, out_src);
    end
    n_chk++;
    if (out_slice !== 4'h2 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_slice_busy: slice=%h busy=%b want 2 0", out_slice, busy);
    end
    @(negedge clk);
    n_chk++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_drain: got %b want 0", out_valid);
    end
    req_data = '0;
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_src;
    logic [3:0] exp_rdy;
    do_reset();
    req_data = 32'h13121110;
    req_last = 4'b1111;
    req_valid = 4'b1111;
    @(negedge clk);
    n_chk++;
    if (req_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL rr_first_grant: got %b want 0001", req_ready);
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      exp_src = 3'(k % 4);
      n_chk++;
      if (out_valid !== 1'b1 || out_src !== exp_src || busy !== 1'b0 ||
          out_data !== (8'h10 + 8'(k % 4))) begin
        n_fail++;
        $display("FAIL rr_beat%0d: v=%b s=%0d d=%h busy=%b want 1 %0d", k, out_valid, out_src, out_data, busy, exp_src);
      end
      if (k == 4) req_valid = '0;
      if (k < 4) begin
        @(negedge clk);
        exp_rdy = 4'b0001 << ((k + 1) % 4);
        n_chk++;
        if (out_valid !== 1'b0 || busy !== 1'b1 || req_ready !== exp_rdy) begin
          n_fail++;
          $display("FAIL rr_gap%0d: v=%b busy=%b rdy=%b want 0 1 %b", k, out_valid, busy, req_ready, exp_rdy);
        end
      end
    end
  endtask

  task automatic test_burst_cap();
    do_reset();
    req_last = 4'b0001;
    req_data[7:0] = 8'hC0;
    req_valid = 4'b0100;
    for (int b = 1; b <= 4; b++) begin
      @(negedge clk);
      req_valid = 4'b0101;
      #1;
      if (b > 1) begin
        n_chk++;
        if (out_valid !== 1'b1 || out_src !== 3'd2 || out_data !== 8'(8'h20 + b - 1)) begin
          n_fail++;
          $display("FAIL cap_beat%0d: v=%b s=%0d d=%h want 1 2 %h", b - 1, out_valid, out_src, out_data, 8'(8'h20 + b - 1));
        end
      end
      n_chk++;
      if (req_ready !== 4'b0100) begin
        n_fail++;
        $display("FAIL cap_ready%0d: got %b want 0100", b, req_ready);
      end
      req_data[23:16] = 8'(8'h20 + b);
    end
    @(negedge clk);
    n_chk++;
    if (out_data !== 8'h24 || out_src !== 3'd2 || busy !== 1'b0 || req_ready !== 4'b0) begin
      n_fail++;
      $display("FAIL cap_end: d=%h s=%0d busy=%b rdy=%b want 24 2 0 0000", out_data, out_src, busy, req_ready);
    end
    @(negedge clk);
    n_chk++;
    if (req_ready !== 4'b0001 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL cap_next_grant: rdy=%b v=%b want 0001 0", req_ready, out_valid);
    end
    @(negedge clk);
    n_chk++;
    if (out_src !== 3'd0 || out_data !== 8'hC0) begin
      n_fail++;
      $display("FAIL cap_req0_beat: s=%0d d=%h want 0 c0", out_src, out_data);
    end
    req_valid = 4'b0100;
    req_data[23:16] = 8'h25;
    @(negedge clk);
    n_chk++;
    if (req_ready !== 4'b0100) begin
      n_fail++;
      $display("FAIL cap_regrant: got %b want 0100", req_ready);
    end
    @(negedge clk);
    req_valid = '0;
    n_chk++;
    if (out_src !== 3'd2 || out_data !== 8'h25) begin
      n_fail++;
      $display("FAIL cap_resume: s=%0d d=%h want 2 25", out_src, out_data);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    req_data[31:24] = 8'h11;
    req_valid = 4'b1000;
    @(negedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    req_data[31:24] = 8'h22;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_chk++;
      if (out_data !== 8'h11 || out_valid !== 1'b1 || req_ready !== 4'b0 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL bp_hold%0d: d=%h v=%b rdy=%b busy=%b want 11 1 0000 1", c, out_data, out_valid, req_ready, busy);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    n_chk++;
    if (req_ready !== 4'b1000) begin
      n_fail++;
      $display("FAIL bp_release: got %b want 1000", req_ready);
    end
    @(negedge clk);
    n_chk++;
    if (out_data !== 8'h22 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_beat2: d=%h v=%b want 22 1", out_data, out_valid);
    end
    req_data[31:24] = 8'h33;
    req_last = 4'b1000;
    @(negedge clk);
    n_chk++;
    if (out_data !== 8'h33 || out_valid !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_beat3: d=%h v=%b busy=%b want 33 1 0", out_data, out_valid, busy);
    end
    req_valid = '0;
    @(negedge clk);
    n_chk++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_drain: got %b want 0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    req_data[15:8] = 8'h0F;
    req_valid = 4'b0010;
    @(negedge clk);
    @(negedge clk);
    n_chk++;
    if (out_valid !== 1'b1 || out_slice !== 4'h7) begin
      n_fail++;
      $display("FAIL b2b_first: v=%b slice=%h want 1 7", out_valid, out_slice);
    end
    req_data[15:8] = 8'hF0;
    req_last = 4'b0010;
    @(negedge clk);
    n_chk++;
    if (out_valid !== 1'b1 || out_slice !== 4'h8 || out_data !== 8'hF0) begin
      n_fail++;
      $display("FAIL b2b_second: v=%b slice=%h d=%h want 1 8 f0", out_valid, out_slice, out_data);
    end
    req_valid = '0;
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    req_data[15:8] = 8'h31;
    req_valid = 4'b0010;
    @(negedge clk);
    @(negedge clk);
    req_data[15:8] = 8'h32;
    #2;
    rst = 1'b1;
    #1;
    n_chk++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 4'b0) begin
      n_fail++;
      $display("FAIL mid_rst_async: v=%b busy=%b rdy=%b want 0 0 0000", out_valid, busy, req_ready);
    end
    @(negedge clk);
    req_valid = 4'b0011;
    rst = 1'b0;
    @(negedge clk);
    n_chk++;
    if (req_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL mid_rst_regrant: got %b want 0001", req_ready);
    end
    req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_burst_cap();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
